// File: rtl/med_pkg.sv
// Shared state encoding, schedule constants and the pass bypass pattern for the
// 9-sample median sequencer.
package med_pkg;

    typedef logic [2:0] med_state_t;

    localparam med_state_t IDLE  = 3'd0;
    localparam med_state_t LOAD  = 3'd1;
    localparam med_state_t PASS  = 3'd2;
    localparam med_state_t FINAL = 3'd3;
    localparam med_state_t HOLD  = 3'd4;

    localparam int unsigned LOAD_CYC  = 9;
    localparam int unsigned PASS_CYC  = 9;
    localparam int unsigned NUM_PASS  = 4;
    localparam int unsigned FINAL_CYC = 4;

    // Pass p compares for the first 8-p cycles, then shifts the p+1 parked maxima along.
    function automatic logic byp_of(input logic [2:0] p, input logic [3:0] cnt);
        logic [3:0] lim;
        lim = 4'(PASS_CYC - 1) - {1'b0, p};
        return (cnt >= lim);
    endfunction

endpackage

// File: rtl/med_seq.sv
// Median sequencer: loads a 9-pixel window into the shift-ring datapath, runs the
// fixed compare/shift schedule and presents the median over a valid/ready port.
import med_pkg::*;

module med_seq #(
    parameter int N    = 7,
    parameter int SIZE = 9
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         S_VALID,
    output logic         S_READY,
    input  logic [N:0]   S_DATA,
    output logic         M_VALID,
    input  logic         M_READY,
    output logic [N:0]   M_DATA,
    output logic [N:0]   DI,
    output logic         DSI,
    output logic         BYP,
    input  logic [N:0]   DO
);

    med_state_t  state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [2:0]  p, p_d;
    logic        err, err_d;
    logic        ready_d;
    logic        mvalid_d;
    logic [N:0]  mdata_d;
    logic        accept;

    assign accept = S_VALID & S_READY;
    assign DI     = S_DATA;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        p_d      = p;
        err_d    = err;
        mvalid_d = M_VALID;
        mdata_d  = M_DATA;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    cnt_d   = 4'd1;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt == 4'(SIZE - 1)) begin
                        state_d = PASS;
                        cnt_d   = '0;
                        p_d     = '0;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end else begin
                    // A stall inside a window is a protocol error: drop the window and lock out.
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            PASS: begin
                if (cnt == 4'(PASS_CYC - 1)) begin
                    cnt_d = '0;
                    if (p == 3'(NUM_PASS - 1)) begin
                        state_d = FINAL;
                        p_d     = '0;
                    end else begin
                        p_d = p + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            FINAL: begin
                if (cnt == 4'(FINAL_CYC - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (!M_VALID) begin
                    mvalid_d = 1'b1;
                    mdata_d  = DO;
                end else if (M_READY) begin
                    mvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                p_d     = '0;
            end
        endcase
        ready_d = ~err_d & ((state_d == IDLE) | (state_d == LOAD));
    end

    always_comb begin
        DSI = 1'b0;
        BYP = 1'b1;
        case (state)
            IDLE, LOAD: DSI = accept;
            PASS:       BYP = byp_of(p, cnt);
            FINAL:      BYP = 1'b0;
            default:    BYP = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            p       <= '0;
            err     <= 1'b0;
            S_READY <= 1'b0;
            M_VALID <= 1'b0;
            M_DATA  <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            p       <= p_d;
            err     <= err_d;
            S_READY <= ready_d;
            M_VALID <= mvalid_d;
            M_DATA  <= mdata_d;
        end
    end

endmodule
